// File: rtl/instr_sequencer.sv
// Program sequencer driving the CPU load/in/s/w handshake.
// Ports: clk, reset, prog_we/addr/data, num_instr, run, cpu_w, cpu_out,
//   cpu_N/V/Z in; cpu_load, cpu_in, cpu_s, busy, done, err, pc,
//   result, flags, count out.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   num_instr,
  input  logic          run,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic          cpu_load,
  output logic [15:0]   cpu_in,
  output logic          cpu_s,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [15:0]   result,
  output logic [2:0]    flags,
  output logic [AW:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WBUSY,
    S_WDONE, S_CAP, S_FIN
  } state_t;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   NMAX = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   n_q;
  logic [AW:0]   n_in;
  logic [AW:0]   cnt_inc;
  logic [WW-1:0] wd;
  logic          tmo;

  assign n_in    = (num_instr > NMAX) ? NMAX : num_instr;
  assign cnt_inc = count + (AW+1)'(1);
  assign tmo     = (wd == WLIM);
  assign busy    = (state != S_IDLE) && (state != S_FIN);
  assign done    = (state == S_FIN);

  // Program store is frozen while a sequence runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      mem[prog_addr] <= prog_data;
  end

  always_comb begin
    state_nx = state;
    cpu_load = 1'b0;
    cpu_s    = 1'b0;
    unique case (state)
      S_IDLE:
        if (run)
          state_nx = (n_in == '0) ? S_FIN : S_LOAD;
      S_LOAD: begin
        cpu_load = 1'b1;
        state_nx = S_START;
      end
      S_START:
        if (cpu_w) begin
          cpu_s    = 1'b1;
          state_nx = S_WBUSY;
        end
      S_WBUSY:
        if (!cpu_w)   state_nx = S_WDONE;
        else if (tmo) state_nx = S_FIN;
      S_WDONE:
        if (cpu_w)    state_nx = S_CAP;
        else if (tmo) state_nx = S_FIN;
      S_CAP:
        state_nx = (cnt_inc == n_q) ? S_FIN : S_LOAD;
      S_FIN:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      n_q    <= '0;
      wd     <= '0;
      pc     <= '0;
      count  <= '0;
      err    <= 1'b0;
      result <= '0;
      flags  <= '0;
      cpu_in <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE:
          if (run) begin
            n_q   <= n_in;
            pc    <= '0;
            count <= '0;
            err   <= 1'b0;
            if (n_in != '0)
              cpu_in <= mem[0];
          end
        S_START:
          if (cpu_w) wd <= '0;
        S_WBUSY, S_WDONE: begin
          // Counter restarts on each phase change.
          if (state_nx != state) wd <= '0;
          else                   wd <= wd + WW'(1);
          if (state_nx == S_FIN) err <= 1'b1;
        end
        S_CAP: begin
          result <= cpu_out;
          flags  <= {cpu_N, cpu_V, cpu_Z};
          count  <= cnt_inc;
          if (cnt_inc != n_q) begin
            pc     <= pc + AW'(1);
            cpu_in <= mem[pc + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of runs against a CPU model,
// scoreboard of expected captures, plus a mid-run reset sequence.
module tb_instr_sequencer;

  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [AW:0]   num_instr;
  logic          run;
  logic          cpu_w;
  logic [15:0]   cpu_out;
  logic          cpu_N, cpu_V, cpu_Z;
  logic          cpu_load, cpu_s, busy, done, err;
  logic [15:0]   cpu_in, result;
  logic [AW-1:0] pc;
  logic [2:0]    flags;
  logic [AW:0]   count;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .num_instr(num_instr), .run(run),
    .cpu_w(cpu_w), .cpu_out(cpu_out),
    .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .cpu_load(cpu_load), .cpu_in(cpu_in), .cpu_s(cpu_s),
    .busy(busy), .done(done), .err(err), .pc(pc),
    .result(result), .flags(flags), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  flags;
    logic [4:0]  count;
    logic        err;
  } exp_t;

  typedef struct {
    int n; int b; int stall; bit hang;
    int ecount; int eloads; int gap;
    int ldgap; int rdgap; int epc; bit eerr;
  } vec_t;

  exp_t        q[$];
  vec_t        vt[8];
  logic [15:0] sh[DEPTH];
  logic [15:0] last_res;
  logic [2:0]  last_flags;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int loads, ss, dones, last_load, run_cyc;
  int cur_gap, cur_ldgap, cur_rdgap;
  int b_k, stall_k;
  bit hang_k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference CPU op: byte swap plus 3; N from msb, V from instr lsb.
  function automatic logic [18:0] f(input logic [15:0] i);
    logic [15:0] o;
    o = {i[7:0], i[15:8]} + 16'd3;
    return {o, o[15], i[0], (o == 16'h0)};
  endfunction

  // CPU model: w drops the cycle after s, stays low b_k cycles.
  initial begin : cpu_model
    logic s_m, l_m;
    logic [15:0] in_m;
    int mcnt, mst;
    cpu_w = 1'b1; cpu_out = '0;
    cpu_N = 0; cpu_V = 0; cpu_Z = 0;
    mcnt = 0; mst = 0;
    forever begin
      @(negedge clk);
      s_m = cpu_s; l_m = cpu_load; in_m = cpu_in;
      @(posedge clk); #1;
      if (reset) begin
        cpu_w = 1'b1; mcnt = 0; mst = 0;
      end else if (s_m) begin
        cpu_w = 1'b0; mcnt = b_k - 1;
        {cpu_out, cpu_N, cpu_V, cpu_Z} = f(in_m);
      end else if (l_m && stall_k > 0) begin
        cpu_w = 1'b0; mst = stall_k;
      end else if (mst > 0) begin
        mst--;
        if (mst == 0) cpu_w = 1'b1;
      end else if (!cpu_w && !hang_k) begin
        if (mcnt > 0) mcnt--;
        else cpu_w = 1'b1;
      end
    end
  end

  // Monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_load && cpu_s) chk("load_s_overlap", 1, 0);
      if (cpu_load) begin
        if (loads < DEPTH) begin
          chk("cpu_in_load", cpu_in, sh[loads]);
          chk("pc_load", pc, loads);
        end
        loads++;
        last_load = cyc;
      end
      if (cpu_s) begin
        ss++;
        chk("load_to_s", cyc - last_load, cur_gap);
      end
      if (done) begin
        exp_t e;
        dones++;
        if (cur_ldgap >= 0)
          chk("load_to_done", cyc - last_load, cur_ldgap);
        if (cur_rdgap >= 0)
          chk("run_to_done", cyc - run_cyc, cur_rdgap);
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", result, e.result);
          chk("flags", flags, e.flags);
          chk("count", count, e.count);
          chk("err", err, e.err);
        end
      end
    end
  end

  task automatic start_run(input int n);
    @(posedge clk); #1;
    num_instr = (AW+1)'(n);
    run = 1'b1;
    loads = 0; ss = 0;
    run_cyc = cyc;
    @(posedge clk); #1;
    run = 1'b0;
    chk("err_clr_on_run", err, 0);
  endtask

  task automatic do_row(input vec_t v);
    exp_t e;
    int ne, d0;
    bit got;
    ne = (v.n > DEPTH) ? DEPTH : v.n;
    b_k = v.b; stall_k = v.stall; hang_k = v.hang;
    cur_gap = v.gap; cur_ldgap = v.ldgap; cur_rdgap = v.rdgap;
    if (ne > 0 && !v.hang) begin
      {last_res, last_flags} = f(sh[ne-1]);
    end
    e.result = last_res; e.flags = last_flags;
    e.count = 5'(v.ecount); e.err = v.eerr;
    q.push_back(e);
    d0 = dones;
    start_run(v.n);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      if (dones > d0) got = 1;
    end
    #1;
    if (!got) chk("done_timeout", 0, 1);
    chk("single_done", dones - d0, 1);
    chk("busy_after", busy, 0);
    chk("n_loads", loads, v.eloads);
    chk("n_starts", ss, v.eloads);
    chk("pc_end", pc, v.epc);
    chk("err_sticky", err, v.eerr);
    hang_k = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int d0;
    bit hit;
    exp_t e;
    reset = 1'b1; prog_we = 0; prog_addr = '0; prog_data = '0;
    num_instr = '0; run = 0;
    loads = 0; ss = 0; dones = 0; last_load = 0; run_cyc = 0;
    cur_gap = 1; cur_ldgap = -1; cur_rdgap = -1;
    b_k = 5; stall_k = 0; hang_k = 0;
    last_res = '0; last_flags = '0;
    for (int i = 0; i < DEPTH; i++)
      sh[i] = 16'hA0A2 ^ 16'(i * 16'h1357);

    vt[0] = '{1, 5, 0, 0, 1, 1, 1, 9, -1, 0, 0};
    vt[1] = '{3, 2, 0, 0, 3, 3, 1, 6, -1, 2, 0};
    vt[2] = '{0, 2, 0, 0, 0, 0, 1, -1, 1, 0, 0};
    vt[3] = '{1, 3, 3, 0, 1, 1, 4, 10, -1, 0, 0};
    vt[4] = '{1, 2, 0, 1, 0, 1, 1, 67, -1, 0, 1};
    vt[5] = '{2, 1, 0, 0, 2, 2, 1, 5, -1, 1, 0};
    vt[6] = '{16, 1, 0, 0, 16, 16, 1, 5, -1, 15, 0};
    vt[7] = '{20, 2, 0, 0, 16, 16, 1, 6, -1, 15, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs",
        {cpu_load, cpu_s, busy, done, err, pc, flags, count},
        0);
    chk("rst_data", {cpu_in, result}, 0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      prog_we = 1; prog_addr = AW'(i); prog_data = sh[i];
    end
    @(posedge clk); #1;
    prog_we = 0;

    foreach (vt[i]) do_row(vt[i]);

    // Reset during WDONE of the second instruction.
    b_k = 6; stall_k = 0; hang_k = 0;
    cur_gap = 1; cur_ldgap = -1; cur_rdgap = -1;
    e.result = '0; e.flags = '0; e.count = '0; e.err = 0;
    q.push_back(e);
    start_run(3);
    prog_we = 1; prog_addr = '0; prog_data = 16'hDEAD;
    @(posedge clk); #1;
    prog_we = 0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (pc == 1 && !cpu_w && busy) hit = 1;
    end
    if (!hit) chk("reach_wdone2", 0, 1);
    @(negedge clk);
    d0 = dones;
    reset = 1'b1;
    #1;
    chk("rst_mid_outs",
        {cpu_load, cpu_s, busy, done, err, pc, flags, count},
        0);
    chk("rst_mid_data", {cpu_in, result}, 0);
    repeat (3) @(posedge clk);
    q.delete();
    last_res = '0; last_flags = '0;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    chk("no_done_on_rst", dones - d0, 0);

    // Program must be unchanged by the write issued while busy.
    do_row('{1, 2, 0, 0, 1, 1, 1, 6, -1, 0, 0});
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
